encoder_8x3_req: RTL and testbench
==================================

Name: encoder_8x3_req

Overview:
- Sequential 8-to-3 priority request encoder; the inverse of decoder_3x8.
- Captures falling edges on eight active-low request lines into a pending register.
- Serves pending requests one at a time as a 3-bit code over a valid/ready handshake. The code can drive decoder_3x8 input i directly.
- Fixed priority: index 0 is highest.

Parameters:
- None. Width is fixed at 8 request lines and a 3-bit code.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  active-low enable. 0 = capture and grant enabled; 1 = capture and new grants blocked.
- req_n  input  8  active-low request lines. A request is a high-to-low transition on a bit.
- code  output  3  index of the granted request; valid only while valid=1
- valid  output  1  code is valid
- ready  input  1  consumer accepts code when valid=1 and ready=1 at a rising edge
- pending  output  8  registered pending-request vector, active-high
- ovr  output  1  sticky overrun flag

Behaviour:
- Reset (asynchronous, rst_n=0):
  - req_q=8'hFF, pending=8'h00, code=3'd0, valid=0, ovr=0, state=IDLE.
  - Reset mid-handshake drops valid immediately and discards all pending requests.
- Edge detect:
  - req_q <= req_n every cycle, regardless of en.
  - fall = req_q & ~req_n.
  - cap = fall when en=0, otherwise 8'h00. Edges seen while en=1 are lost, never deferred.
- Pending update, every cycle: pending <= (pending & ~clr) | cap.
  - clr is one-hot on code when valid & ready, otherwise 0.
  - Set wins: a new edge on a bit cleared in the same cycle leaves the bit pending (re-queued).
- Overrun: ovr <= 1 when cap & pending & ~clr is non-zero. Sticky; cleared only by reset.
- FSM, two states:
  - IDLE: if en=0 and pending!=0, code <= index of the lowest set bit of pending (current register value), valid <= 1, go to GRANT. Otherwise stay in IDLE with valid=0 and code held.
  - GRANT: code and valid are held stable. On valid & ready, valid <= 0 and go to IDLE. Changes to pending or en do not alter code or valid in this state.
  - en=1 while in GRANT: the current grant completes normally; no new grant is issued afterwards.
- Latency:
  - req_n first sampled low at edge k (req_q=1) → pending bit set after edge k → valid=1 after edge k+1.
  - Handshake at edge m → next valid no earlier than after edge m+1.
  - Throughput is at most 1 grant per 2 cycles.
- Priority: lower index wins. Code is 3'b000 for bit 0 through 3'b111 for bit 7.
- Level-held requests: a req_n line held low produces exactly one request; the line must return high before it can request again.
- A glitch shorter than one cycle may be missed; this is acceptable.
- No combinational path from ready or req_n to any output; all outputs are registered.

Test Plan:
- Reset then idle: rst_n=0, then 1, with req_n=8'hFF → valid=0, code=0, pending=8'h00, ovr=0 for 20 cycles.
- Single request: en=0, req_n 8'hFF→8'hDF, ready=1 → pending=8'h20 after 1 edge; valid=1, code=3'b101 after the next edge; pending returns to 8'h00 and valid=0 after the handshake.
- Priority ordering: req_n 8'hFF→8'h6A in one cycle (bits 0, 2, 4, 7), ready=1 → codes 0, 2, 4, 7 issued in that order, each 2 cycles apart; pending ends at 8'h00.
- Backpressure and held level: req_n=8'hFE held low with ready=0 for 10 cycles → valid=1 and code=0 stable throughout, no second capture; ready=1 → single grant, then valid=0.
- Overrun and set-wins:
  - Pulse bit 3 twice while pending[3]=1 and no handshake → ovr=1 and stays 1.
  - Edge on bit 3 in the same cycle as its handshake → pending[3]=1 afterwards and a second grant with code=3.
- Enable and mid-operation reset:
  - en=1 with req_n 8'hFF→8'hF0 → pending stays 8'h00 and valid=0; setting en=0 later issues no grant.
  - rst_n=0 asynchronously while valid=1 → valid=0 and pending=8'h00 immediately, before the next clock edge.

Source files
------------

// File: rtl/encoder_8x3_req.sv
// Purpose: 8-to-3 priority request encoder; latches falling edges on active-low
//          request lines and serves them one at a time as a 3-bit code (bit 0 highest).
// Latency: edge sampled at clock k -> pending after k -> valid after k+1; max 1 grant per 2 cycles.
// Backpressure: code/valid held stable until ready; new edges keep queueing in pending meanwhile.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   en             active-low enable; 1 drops new edges and blocks new grants
//   req_n[7:0]     active-low request lines (a request is a high-to-low transition)
//   code[2:0]      granted index, meaningful only while valid=1
//   valid, ready   grant handshake; accepted on valid & ready at a rising edge
//   pending[7:0]   registered pending-request vector, active-high
//   ovr            sticky overrun: an edge arrived on a bit that was already pending
module encoder_8x3_req (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req_n,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       ovr
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [7:0] req_q;
    logic [7:0] fall;
    logic [7:0] cap;
    logic [7:0] clr;
    logic [2:0] low_idx;

    // Edges that arrive while disabled are dropped outright, not deferred.
    assign fall = req_q & ~req_n;
    assign cap  = en ? 8'h00 : fall;

    // The request being accepted this cycle leaves pending.
    assign clr = (valid && ready) ? (8'b0000_0001 << code) : 8'h00;

    // Lowest set bit of pending; scanning downward lets bit 0 win.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Request sampling, pending queue and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 8'hFF;
            pending <= 8'h00;
            ovr     <= 1'b0;
        end else begin
            req_q   <= req_n;
            // Set wins over clear: an edge on the bit being served re-queues it.
            pending <= (pending & ~clr) | cap;
            if ((cap & pending & ~clr) != 8'h00) begin
                ovr <= 1'b1;
            end
        end
    end

    // Grant FSM. Uses the registered pending value, so a grant always
    // trails the capture by one cycle and a handshake forces one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            code  <= 3'd0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!en && (pending != 8'h00)) begin
                        code  <= low_idx;
                        valid <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8x3_req.sv
module tb_encoder_8x3_req;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req_n;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       ovr;

    int n_cmp;
    int n_err;

    encoder_8x3_req dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req_n   (req_n),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .ovr     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req_n;
        logic       en;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [7:0] exp_pending;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [7:0] r, input logic e, input logic rdy,
                                input logic v, input logic [2:0] c, input logic [7:0] p,
                                input logic o);
        vec_t t;
        t.req_n = r; t.en = e; t.ready = rdy;
        t.exp_valid = v; t.exp_code = c; t.exp_pending = p; t.exp_ovr = o;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [2:0] c,
                             input logic [7:0] p, input logic o);
        check({tag, ".valid"},   {7'd0, valid}, {7'd0, v});
        check({tag, ".code"},    {5'd0, code},  {5'd0, c});
        check({tag, ".pending"}, pending,       p);
        check({tag, ".ovr"},     {7'd0, ovr},   {7'd0, o});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        ready = 1'b0;
        req_n = 8'hFF;

        // Single request on bit 5
        add(8'hDF, 0, 1, 0, 3'd0, 8'h20, 0);
        add(8'hDF, 0, 1, 1, 3'd5, 8'h20, 0);
        add(8'hFF, 0, 1, 0, 3'd5, 8'h00, 0);
        add(8'hFF, 0, 1, 0, 3'd5, 8'h00, 0);
        // Priority ordering: bits 0,2,4,7 at once
        add(8'h6A, 0, 1, 0, 3'd5, 8'h95, 0);
        add(8'h6A, 0, 1, 1, 3'd0, 8'h95, 0);
        add(8'h6A, 0, 1, 0, 3'd0, 8'h94, 0);
        add(8'h6A, 0, 1, 1, 3'd2, 8'h94, 0);
        add(8'h6A, 0, 1, 0, 3'd2, 8'h90, 0);
        add(8'h6A, 0, 1, 1, 3'd4, 8'h90, 0);
        add(8'h6A, 0, 1, 0, 3'd4, 8'h80, 0);
        add(8'h6A, 0, 1, 1, 3'd7, 8'h80, 0);
        add(8'h6A, 0, 1, 0, 3'd7, 8'h00, 0);
        add(8'hFF, 0, 1, 0, 3'd7, 8'h00, 0);
        // Backpressure with a held-low line on bit 0
        add(8'hFE, 0, 0, 0, 3'd7, 8'h01, 0);
        for (int i = 0; i < 10; i++) add(8'hFE, 0, 0, 1, 3'd0, 8'h01, 0);
        add(8'hFE, 0, 1, 0, 3'd0, 8'h00, 0);
        add(8'hFE, 0, 1, 0, 3'd0, 8'h00, 0);
        add(8'hFF, 0, 1, 0, 3'd0, 8'h00, 0);

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 0, 3'd0, 8'h00, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("idle", 0, 3'd0, 8'h00, 0);
        end

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            req_n = vecs[i].req_n;
            en    = vecs[i].en;
            ready = vecs[i].ready;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                      vecs[i].exp_pending, vecs[i].exp_ovr);
        end

        // Set-wins: edge on bit 3 in the same cycle as its handshake
        ready = 1'b0; req_n = 8'hF7;
        tick();
        check("sw.pending0", pending, 8'h08);
        tick();
        check_all("sw.grant1", 1, 3'd3, 8'h08, 0);
        req_n = 8'hFF;
        tick();
        req_n = 8'hF7; ready = 1'b1;
        tick();
        check_all("sw.requeue", 0, 3'd3, 8'h08, 0);
        tick();
        check_all("sw.grant2", 1, 3'd3, 8'h08, 0);
        req_n = 8'hFF;
        tick();
        check_all("sw.done", 0, 3'd3, 8'h00, 0);

        // Overrun: second edge on bit 3 while still pending, no handshake
        ready = 1'b0; req_n = 8'hF7;
        tick();
        tick();
        check_all("ov.grant", 1, 3'd3, 8'h08, 0);
        req_n = 8'hFF;
        tick();
        req_n = 8'hF7;
        tick();
        check("ov.set", {7'd0, ovr}, 8'h01);
        req_n = 8'hFF;
        tick();
        tick();
        check("ov.sticky", {7'd0, ovr}, 8'h01);
        ready = 1'b1;
        tick();
        check_all("ov.drain", 0, 3'd3, 8'h00, 1);

        // en=1 during GRANT: current grant completes, next one is held off
        ready = 1'b0; req_n = 8'hF9;
        tick();
        tick();
        check_all("eng.grant", 1, 3'd1, 8'h06, 1);
        en = 1'b1; ready = 1'b1;
        tick();
        check_all("eng.done", 0, 3'd1, 8'h04, 1);
        tick();
        check_all("eng.block", 0, 3'd1, 8'h04, 1);
        en = 1'b0;
        tick();
        check_all("eng.resume", 1, 3'd2, 8'h04, 1);
        req_n = 8'hFF;
        tick();
        check_all("eng.drain", 0, 3'd2, 8'h00, 1);

        // Disabled edges are lost, not deferred
        en = 1'b1; req_n = 8'hF0;
        tick();
        tick();
        check_all("dis.a", 0, 3'd2, 8'h00, 1);
        en = 1'b0;
        tick();
        tick();
        check_all("dis.b", 0, 3'd2, 8'h00, 1);
        req_n = 8'hFF;
        tick();

        // Asynchronous reset mid-grant
        ready = 1'b0; req_n = 8'hFD;
        tick();
        tick();
        check_all("ar.grant", 1, 3'd1, 8'h02, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("ar.async", 0, 3'd0, 8'h00, 0);
        req_n = 8'hFF;
        tick();
        rst_n = 1'b1;
        tick();
        check_all("ar.after", 0, 3'd0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
